// File: rtl/bist_pkg.sv
// Shared definitions for the BIST scheduler.
// - state_t         : scheduler FSM encoding (2 bits)
// - DEFAULT_TIMEOUT : default watchdog limit in cycles
// - next_ptr()      : round-robin pointer advance with wrap
package bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

  // Pointer to the requester after 'cur', wrapping NUM_REQ-1 back to 0.
  function automatic int unsigned next_ptr(input int unsigned cur, input int unsigned num_req);
    return (cur == num_req - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  IDX_W    index with highest priority this round
//   winner out NUM_REQ  one-hot winner (0 when no request)
//   index  out IDX_W    binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index
);

  logic found;

  // Scan upward from rr_ptr modulo NUM_REQ; first set bit wins.
  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        winner[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
        index = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_scheduler.sv
// Shares one BIST engine between NUM_REQ requesters with round-robin
// arbitration, a session watchdog and abort detection.
// Ports:
//   clock, reset_n      clock / async active-low reset
//   req[NUM_REQ]        level requests, owner holds high until done/err
//   grant[NUM_REQ]      one-hot engine owner, 0 when idle
//   done[NUM_REQ]       1-cycle pulse on owner's bit at normal completion
//   pass                engine result captured at bist_end, valid with done
//   timeout_err         1-cycle pulse, watchdog aborted the session
//   abort_err           1-cycle pulse, owner dropped req mid-session
//   bist_start          to engine, high in START and WAIT
//   bist_end, running, mode   engine status inputs
//   busy                high whenever the FSM is not IDLE
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               pass,
  output logic               timeout_err,
  output logic               abort_err,
  output logic               bist_start,
  input  logic               bist_end,
  input  logic               running,
  input  logic               mode,
  output logic               busy
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [TO_W-1:0]    wdog;
  logic [NUM_REQ-1:0] arb_winner;
  logic [IDX_W-1:0]   arb_index;
  logic               wdog_exp;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (arb_winner),
    .index  (arb_index)
  );

  assign wdog_exp = (wdog == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      wdog        <= '0;
      grant       <= '0;
      done        <= '0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      abort_err   <= 1'b0;
      bist_start  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      abort_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant      <= arb_winner;
            owner      <= arb_index;
            bist_start <= 1'b1;
            busy       <= 1'b1;
            wdog       <= '0;
            state      <= S_START;
          end
        end
        S_START, S_WAIT: begin
          wdog <= wdog + TO_W'(1);
          // Priority: bist_end, then watchdog, then owner abort.
          if (bist_end && state == S_WAIT) begin
            pass       <= mode;
            done       <= grant;
            bist_start <= 1'b0;
            state      <= S_RELEASE;
          end else if (bist_end) begin
            state <= S_WAIT;
          end else if (wdog_exp) begin
            timeout_err <= 1'b1;
            bist_start  <= 1'b0;
            state       <= S_RELEASE;
          end else if (!req[owner]) begin
            abort_err  <= 1'b1;
            bist_start <= 1'b0;
            state      <= S_RELEASE;
          end else if (state == S_START && running) begin
            state <= S_WAIT;
          end
        end
        S_RELEASE: begin
          rr_ptr <= IDX_W'(next_ptr(int'(owner), NUM_REQ));
          // Hold grant until the engine is back at its initial state.
          if (!bist_end && !running) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
